// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the fixed-latency memory responder.
package mem_responder_pkg;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the core (master) and the memory (slave).
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_wr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port byte-enabled synchronous RAM; one read or one write per enabled cycle.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);
    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one outstanding request, commit on the edge entering RESP.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "mem_responder: LATENCY must be in 1..15");
    end

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              req_ready_q, resp_valid_q, err_q, rd_ok_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    // With LATENCY==1 the commit edge is the capture edge, so use the live request.
    logic              live_d;
    logic [ADDR_W-1:0] addr_d;
    logic              wr_d;
    logic [WORD_W-1:0] wdata_d;
    logic [BE_W-1:0]   be_d;
    logic              commit_d, err_d;
    logic [WORD_W-1:0] ram_rdata;

    assign live_d   = (state_q == IDLE);
    assign addr_d   = live_d ? bus.req_addr  : addr_q;
    assign wr_d     = live_d ? bus.req_wr    : wr_q;
    assign wdata_d  = live_d ? bus.req_wdata : wdata_q;
    assign be_d     = live_d ? bus.req_be    : be_q;
    assign err_d    = misaligned(addr_d[1:0]) || (addr_d[ADDR_W-1:2] >= DEPTH_L);
    assign commit_d = (LATENCY == 1) ? (live_d && bus.req_valid)
                                     : (state_q == WAIT && cnt_q == 4'd0);

    mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_mem (
        .clk    (clk),
        .en_i   (commit_d && !err_d && !rst),
        .we_i   (wr_d),
        .idx_i  (addr_d[IDX_W+1:2]),
        .be_i   (be_d),
        .wdata_i(wdata_d),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            if (commit_d) begin
                err_q   <= err_d;
                rd_ok_q <= !err_d && !wr_d;
            end
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    addr_q      <= bus.req_addr;
                    wr_q        <= bus.req_wr;
                    wdata_q     <= bus.req_wdata;
                    be_q        <= bus.req_be;
                    req_ready_q <= 1'b0;
                    if (LATENCY == 1) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_INIT;
                    end
                end
                WAIT: if (cnt_q == 4'd0) begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                RESP: if (bus.resp_ready) begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    err_q        <= 1'b0;
                    rd_ok_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rd_ok_q ? ram_rdata : '0;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's instruction/data fetch interface, with a valid/ready request and response handshake.
- Holds a word-organised RAM and services one outstanding request at a time.
- Response latency is fixed and programmable, so the core's fetch/stall logic can be exercised against a slow memory instead of the single-cycle memory2c model.
- Reports misaligned and out-of-range accesses as errors rather than wrapping.

Parameters:
- ADDR_W, 32, request address width in bits.
- DEPTH_WORDS, 1024, number of 32-bit words in the array.
- LATENCY, 2, cycles from request handshake to resp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  ADDR_W  byte address.
- req_wr  input  1  1 = write, 0 = read.
- req_wdata  input  32  write data.
- req_be  input  4  byte enables for writes; bit i enables wdata[8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts response.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_err  output  1  access was misaligned or out of range.

Behaviour:
- Reset (rst high at a rising edge):
  - state becomes IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture addr/wr/wdata/be.
  - If LATENCY==1, go to RESP. Otherwise load counter=LATENCY-2 and go to WAIT.
- WAIT:
  - req_ready=0; decrement counter each cycle.
  - When counter==0, go to RESP.
- Access commit: happens on the edge that enters RESP.
  - Read: latch RAM word into resp_rdata.
  - Write: update only the enabled bytes; resp_rdata=0.
  - Error (addr[1:0]!=0 or addr[ADDR_W-1:2] >= DEPTH_WORDS): no RAM access, resp_err=1, resp_rdata=0.
- Latency: request handshake on edge E0; resp_valid is high starting after edge E_LATENCY.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until the handshake.
  - On resp_ready, go to IDLE; resp_valid drops next cycle.
  - A new request can be accepted one cycle after the response handshake, never in the same cycle.
- req_ready=0 in WAIT and RESP; req_* inputs are ignored there.
- resp_ready is ignored when resp_valid=0.
- Write of req_be=0: legal, no RAM change, normal response, resp_err=0.
- Read-after-write to the same word in consecutive transactions returns the new data.
- Reset mid-operation:
  - In WAIT: the transaction is dropped and the pending write never commits.
  - In RESP: the response is discarded; a committed write remains.
- Address index uses addr[ADDR_W-1:2]; there is no wrap-around (out of range → error).
- LATENCY outside 1..15 is a static error; flag it with an elaboration-time check.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WAIT, RESP);
  - word/byte-enable width constants (WORD_W=32, BE_W=4);
  - the alignment-error helper (addr[1:0]!=0).
- One sub-module is natural: mem_array, a single-port byte-enabled synchronous RAM (DEPTH_WORDS×32, one read-or-write per cycle).
- The FSM, counter and error check live in mem_responder.

Test Plan:
- Reset then idle (LATENCY=2): rst high 2 cycles → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Write then read: write addr 0x10, wdata 0xDEADBEEF, be=4'hF, then read 0x10 →
  - write response: resp_rdata=0, resp_err=0;
  - read response arrives 2 cycles after its handshake with 0xDEADBEEF.
- Byte enables: write 0x11223344 to 0x20, then write 0x000000AA with be=4'b0001, then read → 0x112233AA.
- Error: read 0x22 (misaligned), then read 0x1000 (index 1024) →
  - both give resp_err=1, resp_rdata=0;
  - a prior write of 0x55 at 0x0 still reads back 0x55.
- Backpressure and stall: hold resp_ready=0 for 5 cycles after resp_valid →
  - resp_valid and data stay stable, req_ready=0 throughout;
  - a req_valid offered meanwhile is not accepted.
- Reset mid-WAIT (LATENCY=4): issue write 0xCAFEF00D to 0x40, assert rst 2 cycles after the handshake →
  - no response;
  - a later read of 0x40 returns its prior value, 0.
